// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_bank
// Description : Lock-qualified bank of independent integer clock dividers with
//               glitch-free, period-aligned ratio updates.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_bank #(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pll_locked,
    input  logic [NUM_CH-1:0]         ch_en,
    input  logic [NUM_CH*CNT_W-1:0]   div_val,
    input  logic                      div_load,
    output logic [NUM_CH-1:0]         clk_div,
    output logic [NUM_CH-1:0]         clk_en,
    output logic                      ready
);

    localparam logic [1:0]       c_ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0]       c_ST_STABILIZE = 2'd1;
    localparam logic [1:0]       c_ST_RUN       = 2'd2;
    localparam int               c_STAB_W       = 8;
    localparam logic [c_STAB_W-1:0] c_STAB_LAST = c_STAB_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_DEFAULT_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] c_ONE          = CNT_W'(1);

    logic                r_sync1;
    logic                r_lock_s;
    logic [1:0]          r_state;
    logic [c_STAB_W-1:0] r_stab_cnt;
    logic                r_ready;
    logic                w_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1  <= 1'b0;
            r_lock_s <= 1'b0;
        end else begin
            r_sync1  <= pll_locked;
            r_lock_s <= r_sync1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_ST_WAIT_LOCK;
            r_stab_cnt <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_ready <= (r_state == c_ST_RUN);
            case (r_state)
                c_ST_WAIT_LOCK: begin
                    if (r_lock_s) begin
                        r_state    <= c_ST_STABILIZE;
                        r_stab_cnt <= '0;
                    end
                end
                c_ST_STABILIZE: begin
                    if (!r_lock_s) begin
                        r_state <= c_ST_WAIT_LOCK;
                    end else if (r_stab_cnt == c_STAB_LAST) begin
                        r_state <= c_ST_RUN;
                    end else begin
                        r_stab_cnt <= r_stab_cnt + 1'b1;
                    end
                end
                c_ST_RUN: begin
                    if (!r_lock_s) begin
                        r_state <= c_ST_WAIT_LOCK;
                    end
                end
                default: r_state <= c_ST_WAIT_LOCK;
            endcase
        end
    end

    // Channels drop out on the same edge the FSM leaves RUN.
    assign w_run = (r_state == c_ST_RUN) && r_lock_s;
    assign ready = r_ready;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] r_active_div;
            logic [CNT_W-1:0] r_shadow_div;
            logic             r_div;
            logic             r_en;
            logic             w_active;
            logic             w_bypass;
            logic             w_wrap;
            logic [CNT_W-1:0] w_half;

            assign w_active = w_run && ch_en[i];
            assign w_bypass = (r_active_div <= c_ONE);
            assign w_wrap   = (r_cnt == r_active_div - c_ONE);
            assign w_half   = r_active_div >> 1;

            // The active ratio only follows the shadow at a period boundary,
            // so a ratio change never shortens or stretches a running period.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt        <= '0;
                    r_active_div <= c_DEFAULT_DIV;
                    r_shadow_div <= c_DEFAULT_DIV;
                    r_div        <= 1'b0;
                    r_en         <= 1'b0;
                end else begin
                    if (div_load) begin
                        r_shadow_div <= div_val[i*CNT_W +: CNT_W];
                    end
                    if (!w_active) begin
                        r_cnt        <= '0;
                        r_div        <= 1'b0;
                        r_en         <= 1'b0;
                        r_active_div <= r_shadow_div;
                    end else if (w_bypass) begin
                        r_cnt        <= '0;
                        r_div        <= 1'b0;
                        r_en         <= 1'b1;
                        r_active_div <= r_shadow_div;
                    end else begin
                        r_div <= (r_cnt < w_half);
                        r_en  <= w_wrap;
                        if (w_wrap) begin
                            r_cnt        <= '0;
                            r_active_div <= r_shadow_div;
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                end
            end

            assign clk_div[i] = r_div;
            assign clk_en[i]  = r_en;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_div_bank
// Description : Self-checking bench for clk_div_bank against a period-pattern
//               reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    localparam int NUM_CH      = 2;
    localparam int CNT_W       = 8;
    localparam int LOCK_CYCLES = 16;
    localparam int DEFAULT_DIV = 2;

    logic                    clk        = 1'b0;
    logic                    rst_n      = 1'b0;
    logic                    pll_locked = 1'b0;
    logic                    div_load   = 1'b0;
    logic [NUM_CH-1:0]       ch_en      = '0;
    logic [NUM_CH*CNT_W-1:0] div_val    = '0;
    logic [NUM_CH-1:0]       clk_div;
    logic [NUM_CH-1:0]       clk_en;
    logic                    ready;

    clk_div_bank #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pll_locked (pll_locked),
        .ch_en      (ch_en),
        .div_val    (div_val),
        .div_load   (div_load),
        .clk_div    (clk_div),
        .clk_en     (clk_en),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: lock qualification as a run-length of synchronised
    // lock samples; each channel plays out whole-period output patterns.
    bit              m_lk1, m_lk2;
    int              m_k;
    int              m_shadow [NUM_CH];
    int              m_next_n [NUM_CH];
    int              m_q      [NUM_CH][$];
    bit [NUM_CH-1:0] exp_div, exp_en;
    bit              exp_ready;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_lk1 = 0; m_lk2 = 0; m_k = 0;
        exp_div = '0; exp_en = '0; exp_ready = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            m_shadow[c] = DEFAULT_DIV;
            m_next_n[c] = DEFAULT_DIV;
            m_q[c].delete();
        end
    endtask

    task automatic model_edge();
        bit lock_s, was_run;
        int shadow_pre, n, v;
        if (!rst_n) begin
            model_reset();
        end else begin
            lock_s  = m_lk2;
            m_lk2   = m_lk1;
            m_lk1   = pll_locked;
            was_run = (m_k >= LOCK_CYCLES + 1);
            m_k     = lock_s ? ((m_k < 100000) ? m_k + 1 : m_k) : 0;
            exp_ready = was_run;
            for (int c = 0; c < NUM_CH; c++) begin
                shadow_pre = m_shadow[c];
                if (div_load) m_shadow[c] = int'(div_val[c*CNT_W +: CNT_W]);
                if (!(was_run && lock_s && ch_en[c])) begin
                    m_q[c].delete();
                    exp_div[c]  = 0;
                    exp_en[c]   = 0;
                    m_next_n[c] = shadow_pre;
                end else begin
                    if (m_q[c].size() == 0) begin
                        n = m_next_n[c];
                        if (n <= 1) begin
                            m_q[c].push_back(1);
                        end else begin
                            for (int j = 0; j < n; j++)
                                m_q[c].push_back(((j < n / 2) ? 2 : 0) + ((j == n - 1) ? 1 : 0));
                        end
                    end
                    v = m_q[c].pop_front();
                    exp_div[c] = (v / 2) != 0;
                    exp_en[c]  = (v % 2) != 0;
                    if (m_q[c].size() == 0) m_next_n[c] = shadow_pre;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("clk_div", int'(clk_div), int'(exp_div));
        chk("clk_en",  int'(clk_en),  int'(exp_en));
        chk("ready",   int'(ready),   int'(exp_ready));
    endtask

    task automatic wait_en(input int ch, output int gap);
        gap = 0;
        do begin
            step();
            gap++;
        end while (clk_en[ch] !== 1'b1 && gap < 100);
    endtask

    task automatic wait_ready(output int lat);
        lat = 0;
        do begin
            step();
            lat++;
        end while (ready !== 1'b1 && lat < 200);
    endtask

    initial begin
        int lat, g, n_en, n_div;
        logic [19:0] s_div0, s_div1, s_en0, s_en1;

        model_reset();
        pll_locked = 1'b1;
        ch_en      = 2'b11;
        div_val    = {8'd5, 8'd4};
        repeat (3) step();
        chk("reset_clk_div", int'(clk_div), 0);
        chk("reset_clk_en",  int'(clk_en),  0);
        chk("reset_ready",   int'(ready),   0);

        // Lock held from reset release; shadow loaded while still locking.
        rst_n    = 1'b1;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_ready(lat);
        chk("lock_latency", lat + 1, 20);

        s_div0 = '0; s_div1 = '0; s_en0 = '0; s_en1 = '0;
        for (int j = 0; j < 20; j++) begin
            if (j > 0) step();
            s_div0 = {s_div0[18:0], clk_div[0]};
            s_div1 = {s_div1[18:0], clk_div[1]};
            s_en0  = {s_en0[18:0],  clk_en[0]};
            s_en1  = {s_en1[18:0],  clk_en[1]};
        end
        chk("ch0_div_pattern", int'(s_div0), 'hCCCCC);
        chk("ch1_div_pattern", int'(s_div1), 'hC6318);
        chk("ch0_en_pattern",  int'(s_en0),  'h11111);
        chk("ch1_en_pattern",  int'(s_en1),  'h08421);

        // Ratio 4 -> 6 requested one cycle into a period.
        wait_en(0, g);
        div_val = {8'd5, 8'd6}; div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_en(0, g); chk("midload_gap_old", g + 1, 4);
        wait_en(0, g); chk("midload_gap_new", g, 6);

        div_val = {8'd5, 8'd4}; div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_en(0, g);
        wait_en(0, g);
        // Load on the wrap edge itself: one more old-ratio period first.
        repeat (3) step();
        div_val = {8'd5, 8'd6}; div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("boundary_en", int'(clk_en[0]), 1);
        wait_en(0, g); chk("boundary_gap_old", g, 4);
        wait_en(0, g); chk("boundary_gap_new", g, 6);

        // Bypass ratios 1 and 0.
        div_val = {8'd5, 8'd1}; div_load = 1'b1;
        step();
        div_load = 1'b0;
        wait_en(0, g);
        n_en = 0; n_div = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            n_en  += int'(clk_en[0]);
            n_div += int'(clk_div[0]);
        end
        chk("bypass1_en_count",  n_en, 8);
        chk("bypass1_div_count", n_div, 0);
        div_val = {8'd5, 8'd0}; div_load = 1'b1;
        step();
        div_load = 1'b0;
        n_en = 0; n_div = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            n_en  += int'(clk_en[0]);
            n_div += int'(clk_div[0]);
        end
        chk("bypass0_en_count",  n_en, 8);
        chk("bypass0_div_count", n_div, 0);

        // Disabling channel 0 must not disturb channel 1.
        wait_en(1, g);
        ch_en = 2'b10;
        wait_en(1, g); chk("ch1_gap_after_disable", g, 5);
        wait_en(1, g); chk("ch1_gap_steady", g, 5);
        chk("ch0_disabled_en",  int'(clk_en[0]),  0);
        chk("ch0_disabled_div", int'(clk_div[0]), 0);
        ch_en = 2'b11;
        div_val = {8'd5, 8'd4}; div_load = 1'b1;
        step();
        div_load = 1'b0;
        repeat (10) step();

        // Lock loss in RUN.
        pll_locked = 1'b0;
        repeat (3) step();
        chk("drop_clk_div", int'(clk_div), 0);
        chk("drop_clk_en",  int'(clk_en),  0);
        step();
        chk("drop_ready", int'(ready), 0);
        pll_locked = 1'b1;
        wait_ready(lat);
        chk("relock_latency", lat, 20);

        // Asynchronous reset in the middle of a period.
        repeat (5) step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_clk_div", int'(clk_div), 0);
        chk("async_rst_clk_en",  int'(clk_en),  0);
        chk("async_rst_ready",   int'(ready),   0);
        repeat (2) step();
        rst_n = 1'b1;

        // One-cycle lock glitch during STABILIZE restarts qualification.
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 8) pll_locked = 1'b0;
            if (lat == 9) pll_locked = 1'b1;
        end while (ready !== 1'b1 && lat < 200);
        chk("glitch_latency", lat, 29);

        // Randomized traffic.
        for (int j = 0; j < 3000; j++) begin
            pll_locked = ($urandom_range(0, 399) != 0);
            if ($urandom_range(0, 15) == 0) ch_en = NUM_CH'($urandom_range(0, 3));
            div_load = ($urandom_range(0, 7) == 0);
            if (div_load)
                div_val = {8'($urandom_range(0, 7)), 8'($urandom_range(0, 7))};
            step();
        end
        div_load = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
